// File: rtl/clean_beats_nios2_oci_dct_packer_pkg.sv
// Shared widths, atom codes and output-register state type for the OCI data-trace packer.
// The build macro CLEAN_BEATS_DCT_DROP_CNT_EN is consumed by the top module only.
package clean_beats_oci_pkg;
    localparam int ATOM_W = 2;
    localparam int SLOTS  = 15;
    localparam int BUF_W  = ATOM_W * SLOTS;
    localparam int CNT_W  = $clog2(SLOTS + 1);
    localparam int SH_W   = $clog2(BUF_W);

    typedef logic [ATOM_W-1:0] atom_t;

    localparam atom_t ATOM_PAD   = 2'b00;
    localparam atom_t ATOM_LOAD  = 2'b01;
    localparam atom_t ATOM_STORE = 2'b10;
    localparam atom_t ATOM_SYNC  = 2'b11;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;
endpackage

// File: rtl/clean_beats_nios2_oci_dct_packer_if.sv
// Frame output handshake between the packer and the trace FIFO.
interface clean_beats_nios2_oci_dct_packer_if;
    import clean_beats_oci_pkg::*;

    logic             out_valid;
    logic             out_ready;
    logic [BUF_W-1:0] out_data;
    logic [CNT_W-1:0] out_count;

    modport master (output out_valid, output out_data, output out_count, input out_ready);
    modport slave  (input out_valid, input out_data, input out_count, output out_ready);
endinterface

// File: rtl/clean_beats_nios2_oci_dct_packer_frame_reg.sv
// Single-entry output register: loads closed frames, holds them until accepted,
// and reports a close that arrives while a frame is stalled.
module clean_beats_oci_frame_reg
    import clean_beats_oci_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             close,
    input  logic [BUF_W-1:0] close_data,
    input  logic [CNT_W-1:0] close_count,
    output logic             blocked,
    clean_beats_nios2_oci_dct_packer_if.master frm
);
    out_state_e state;
    out_state_e state_next;
    logic       load;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= OUT_EMPTY;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        blocked    = 1'b0;
        case (state)
            OUT_EMPTY: begin
                if (close) begin
                    load       = 1'b1;
                    state_next = OUT_FULL;
                end
            end
            OUT_FULL: begin
                // A handshake frees the slot in the same cycle, so a close can reload it.
                if (frm.out_ready) begin
                    if (close) load = 1'b1;
                    else       state_next = OUT_EMPTY;
                end else if (close) begin
                    blocked = 1'b1;
                end
            end
            default: state_next = OUT_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frm.out_data  <= '0;
            frm.out_count <= '0;
        end else if (load) begin
            frm.out_data  <= close_data;
            frm.out_count <= close_count;
        end
    end

    assign frm.out_valid = (state == OUT_FULL);
endmodule

// File: rtl/clean_beats_nios2_oci_dct_packer.sv
// Packs 2-bit trace atoms into 30-bit frames and exposes the live packing state.
// Define CLEAN_BEATS_DCT_DROP_CNT_EN to build the saturating dropped-atom counter.
module clean_beats_nios2_oci_dct_packer
    import clean_beats_oci_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             atom_valid,
    input  atom_t            atom,
    input  logic             flush,
    input  logic             overflow_clr,
    output logic [BUF_W-1:0] dct_buffer,
    output logic [CNT_W-1:0] dct_count,
    output logic             overflow,
    output logic [15:0]      drop_count,
    clean_beats_nios2_oci_dct_packer_if.master frm
);
    logic [BUF_W-1:0] buf_acc;
    logic [CNT_W-1:0] cnt_acc;
    logic [SH_W-1:0]  shamt;
    logic [BUF_W-1:0] close_data;
    logic             close;
    logic             blocked;

    // Post-acceptance view: the atom of this cycle is part of any frame closed now.
    always_comb begin
        buf_acc    = atom_valid ? {dct_buffer[BUF_W-ATOM_W-1:0], atom} : dct_buffer;
        cnt_acc    = dct_count + CNT_W'(atom_valid);
        close      = (cnt_acc == CNT_W'(SLOTS)) || (flush && (cnt_acc != '0));
        shamt      = SH_W'(ATOM_W * (SLOTS - int'(cnt_acc)));
        close_data = buf_acc << shamt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dct_buffer <= '0;
            dct_count  <= '0;
        end else if (close) begin
            dct_buffer <= '0;
            dct_count  <= '0;
        end else begin
            dct_buffer <= buf_acc;
            dct_count  <= cnt_acc;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)          overflow <= 1'b0;
        else if (blocked)      overflow <= 1'b1;
        else if (overflow_clr) overflow <= 1'b0;
    end

`ifdef CLEAN_BEATS_DCT_DROP_CNT_EN
    logic [16:0] drop_sum;

    // A clear in the same cycle as a drop restarts the count from this frame's atoms.
    always_comb drop_sum = {1'b0, (overflow_clr ? 16'h0000 : drop_count)} + 17'(cnt_acc);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)          drop_count <= '0;
        else if (blocked)      drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        else if (overflow_clr) drop_count <= '0;
    end
`else
    assign drop_count = '0;
`endif

    clean_beats_oci_frame_reg u_frame_reg (
        .clk         (clk),
        .reset_n     (reset_n),
        .close       (close),
        .close_data  (close_data),
        .close_count (cnt_acc),
        .blocked     (blocked),
        .frm         (frm)
    );
endmodule

// File: tb/tb_clean_beats_nios2_oci_dct_packer.sv
// Self-checking bench for the OCI data-trace packer: vector table, corner sequences,
// and randomized traffic against a queue-based frame model.
module tb_clean_beats_nios2_oci_dct_packer;
    import clean_beats_oci_pkg::*;

`ifdef CLEAN_BEATS_DCT_DROP_CNT_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        atom_valid = 1'b0;
    logic [1:0]  atom = 2'b00;
    logic        flush = 1'b0;
    logic        overflow_clr = 1'b0;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        overflow;
    logic [15:0] drop_count;

    clean_beats_nios2_oci_dct_packer_if frm();

    clean_beats_nios2_oci_dct_packer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .atom_valid   (atom_valid),
        .atom         (atom),
        .flush        (flush),
        .overflow_clr (overflow_clr),
        .dct_buffer   (dct_buffer),
        .dct_count    (dct_count),
        .overflow     (overflow),
        .drop_count   (drop_count),
        .frm          (frm)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: atoms of the open frame, plus the single held output frame.
    logic [1:0]  mq[$];
    bit          m_full;
    logic [29:0] m_data;
    int          m_cnt;
    bit          m_ovf;
    int          m_drop;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_full = 0; m_data = '0; m_cnt = 0; m_ovf = 0; m_drop = 0;
    endfunction

    function automatic void model_step(logic v, logic [1:0] a, logic f, logic r, logic c);
        bit          set = 0;
        logic [29:0] fd = '0;
        int          n;
        if (v) mq.push_back(a);
        n = mq.size();
        if (n == 15 || (f && n > 0)) begin
            // First atom is left-most, pad slots stay zero.
            for (int i = 0; i < n; i++) fd |= 30'(mq[i]) << (28 - 2 * i);
            if (m_full && !r) begin
                set = 1;
                m_drop = (c ? 0 : m_drop) + n;
                if (m_drop > 65535) m_drop = 65535;
            end else begin
                m_full = 1; m_data = fd; m_cnt = n;
            end
            mq.delete();
        end else if (m_full && r) begin
            m_full = 0;
        end
        if (set) m_ovf = 1;
        else if (c) begin
            m_ovf = 0;
            m_drop = 0;
        end
    endfunction

    function automatic logic [29:0] model_buffer();
        logic [29:0] b = '0;
        foreach (mq[i]) b = (b << 2) | 30'(mq[i]);
        return b;
    endfunction

    function automatic void compare_model(string tag);
        chk({tag, ".dct_buffer"}, 32'(dct_buffer), 32'(model_buffer()));
        chk({tag, ".dct_count"},  32'(dct_count),  32'(mq.size()));
        chk({tag, ".out_valid"},  32'(frm.out_valid), 32'(m_full));
        if (m_full) begin
            chk({tag, ".out_data"},  32'(frm.out_data),  32'(m_data));
            chk({tag, ".out_count"}, 32'(frm.out_count), 32'(m_cnt));
        end
        chk({tag, ".overflow"},   32'(overflow),   32'(m_ovf));
        chk({tag, ".drop_count"}, 32'(drop_count), DROP_EN ? 32'(m_drop) : 32'd0);
    endfunction

    task automatic cycle(input logic v, input logic [1:0] a, input logic f,
                         input logic r, input logic c, input string tag);
        atom_valid = v; atom = a; flush = f; frm.out_ready = r; overflow_clr = c;
        @(posedge clk);
        model_step(v, a, f, r, c);
        #1;
        compare_model(tag);
    endtask

    // Asserts reset between edges and checks that state is gone before any clock.
    task automatic do_reset(input string tag);
        #2;
        reset_n = 1'b0;
        atom_valid = 0; flush = 0; overflow_clr = 0; frm.out_ready = 0;
        #1;
        chk({tag, ".rst_buffer"},   32'(dct_buffer),    32'd0);
        chk({tag, ".rst_count"},    32'(dct_count),     32'd0);
        chk({tag, ".rst_valid"},    32'(frm.out_valid), 32'd0);
        chk({tag, ".rst_data"},     32'(frm.out_data),  32'd0);
        chk({tag, ".rst_ocount"},   32'(frm.out_count), 32'd0);
        chk({tag, ".rst_overflow"}, 32'(overflow),      32'd0);
        chk({tag, ".rst_drop"},     32'(drop_count),    32'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic        v;
        logic [1:0]  a;
        logic        f;
        logic        r;
        logic        c;
        logic [3:0]  e_cnt;
        logic        e_ov;
        logic [3:0]  e_ocnt;
        logic [29:0] e_odata;
        logic        e_ovf;
    } vec_t;

    vec_t tbl[11];

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        frm.out_ready = 1'b0;
        model_reset();

        tbl[0]  = '{1'b1, 2'd3, 1'b0, 1'b1, 1'b0, 4'd1, 1'b0, 4'd0, 30'h0,        1'b0};
        tbl[1]  = '{1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 4'd2, 1'b0, 4'd0, 30'h0,        1'b0};
        tbl[2]  = '{1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 4'd3, 1'b0, 4'd0, 30'h0,        1'b0};
        tbl[3]  = '{1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 4'd3, 30'h39000000, 1'b0};
        tbl[4]  = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 30'h0,        1'b0};
        tbl[5]  = '{1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 30'h0,        1'b0};
        tbl[6]  = '{1'b1, 2'd1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 4'd1, 30'h10000000, 1'b0};
        tbl[7]  = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 4'd1, 30'h10000000, 1'b0};
        tbl[8]  = '{1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 4'd1, 30'h10000000, 1'b1};
        tbl[9]  = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 4'd0, 30'h0,        1'b0};
        tbl[10] = '{1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 4'd1, 1'b0, 4'd0, 30'h0,        1'b0};

        @(posedge clk);
        #1;
        do_reset("init");

        for (int i = 0; i < 11; i++) begin
            cycle(tbl[i].v, tbl[i].a, tbl[i].f, tbl[i].r, tbl[i].c, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d.cnt", i), 32'(dct_count),     32'(tbl[i].e_cnt));
            chk($sformatf("vec%0d.ov", i),  32'(frm.out_valid), 32'(tbl[i].e_ov));
            chk($sformatf("vec%0d.ovf", i), 32'(overflow),      32'(tbl[i].e_ovf));
            if (tbl[i].e_ov) begin
                chk($sformatf("vec%0d.odata", i), 32'(frm.out_data),  32'(tbl[i].e_odata));
                chk($sformatf("vec%0d.ocnt", i),  32'(frm.out_count), 32'(tbl[i].e_ocnt));
            end
        end

        // Full frame of LOAD atoms.
        do_reset("full");
        for (int i = 0; i < 14; i++) cycle(1, ATOM_LOAD, 0, 1, 0, "full");
        chk("full.cnt14", 32'(dct_count), 32'd14);
        cycle(1, ATOM_LOAD, 0, 1, 0, "full");
        chk("full.valid", 32'(frm.out_valid), 32'd1);
        chk("full.data",  32'(frm.out_data),  32'h15555555);
        chk("full.count", 32'(frm.out_count), 32'd15);
        chk("full.cnt0",  32'(dct_count),     32'd0);

        // Atom together with flush on the 15th slot: one frame only.
        do_reset("same");
        for (int i = 0; i < 14; i++) cycle(1, ATOM_STORE, 0, 1, 0, "same");
        cycle(1, ATOM_SYNC, 1, 1, 0, "same");
        chk("same.count", 32'(frm.out_count), 32'd15);
        chk("same.data",  32'(frm.out_data),  32'h2AAAAAAB);
        cycle(0, 0, 1, 1, 0, "same");
        chk("same.no2nd", 32'(frm.out_valid), 32'd0);

        // Stalled output: second full frame is dropped.
        do_reset("stall");
        for (int i = 0; i < 15; i++) cycle(1, ATOM_LOAD, 0, 0, 0, "stall");
        for (int i = 0; i < 15; i++) cycle(1, ATOM_SYNC, 0, 0, 0, "stall");
        chk("stall.valid", 32'(frm.out_valid), 32'd1);
        chk("stall.data",  32'(frm.out_data),  32'h15555555);
        chk("stall.ovf",   32'(overflow),      32'd1);
        chk("stall.drop",  32'(drop_count),    DROP_EN ? 32'd15 : 32'd0);

        // Back-to-back reload with handshake in the closing cycle.
        cycle(0, 0, 0, 0, 1, "b2b");
        chk("b2b.clr", 32'(overflow), 32'd0);
        for (int i = 0; i < 14; i++) cycle(1, ATOM_STORE, 0, 0, 0, "b2b");
        cycle(1, ATOM_STORE, 0, 1, 0, "b2b");
        chk("b2b.valid", 32'(frm.out_valid), 32'd1);
        chk("b2b.data",  32'(frm.out_data),  32'h2AAAAAAA);
        chk("b2b.ovf",   32'(overflow),      32'd0);

        // Reset in the middle of a frame, then an empty flush.
        for (int i = 0; i < 7; i++) cycle(1, ATOM_SYNC, 0, 0, 0, "midrst");
        do_reset("midrst");
        cycle(0, 0, 1, 1, 0, "midrst");
        chk("midrst.noframe", 32'(frm.out_valid), 32'd0);

        // Randomized traffic against the model.
        do_reset("rand");
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0,
                  2'($urandom_range(0, 3)),
                  ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0,
                  "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
